// File: rtl/maze_map_port.sv
// maze_map_port: round-robin multi-channel map lookup port; converts world
// coordinates to a linear map address, reads a latency-L memory, returns per-channel cells.
module maze_map_port #(
   parameter int NUM_CH = 4,
   parameter int COORD_W = 10,
   parameter int SCALE_SHIFT = 1,
   parameter int MAP_WIDTH = 320,
   parameter int MAP_HEIGHT = 240,
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8,
   parameter int ROM_LATENCY = 1,
   parameter logic [DATA_W-1:0] OOB_VALUE = DATA_W'(8'hFF)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           req_valid,
   output logic [NUM_CH-1:0]           req_ready,
   input  logic [NUM_CH*COORD_W-1:0]   req_col,
   input  logic [NUM_CH*COORD_W-1:0]   req_row,
   output logic [NUM_CH-1:0]           rsp_valid,
   output logic [NUM_CH*DATA_W-1:0]    rsp_data,
   output logic [NUM_CH-1:0]           rsp_oob,
   output logic                        mem_en,
   output logic [ADDR_W-1:0]           mem_addr,
   input  logic [DATA_W-1:0]           mem_dout
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int FW = COORD_W + 32;
   localparam int L = ROM_LATENCY;

   logic [CW-1:0] last_q, last_d, gnt_idx, cand;
   logic gnt_any;
   logic [COORD_W-1:0] col_w, row_w, col_s, row_s;
   logic oob;
   logic [ADDR_W-1:0] addr;
   logic s1_v_q, s1_v_d, s1_oob_q, s1_oob_d;
   logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
   logic [CW-1:0] s1_ch_q, s1_ch_d;
   logic [L-1:0] pv_q, pv_d, po_q, po_d;
   logic [CW-1:0] pc_q [L];
   logic [CW-1:0] pc_d [L];
   logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d, rsp_oob_q, rsp_oob_d;
   logic [NUM_CH*DATA_W-1:0] rsp_data_q, rsp_data_d;

   // Scan from lowest to highest priority so the channel right after last_q wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         cand = CW'((int'(last_q) + k) % NUM_CH);
         if (req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign req_ready = (gnt_any && !reset) ? NUM_CH'(1) << gnt_idx : '0;

   always_comb begin
      col_w = req_col[gnt_idx*COORD_W +: COORD_W];
      row_w = req_row[gnt_idx*COORD_W +: COORD_W];
      col_s = col_w >> SCALE_SHIFT;
      row_s = row_w >> SCALE_SHIFT;
      oob = !(FW'(col_s) < FW'(MAP_WIDTH) && FW'(row_s) < FW'(MAP_HEIGHT));
      addr = ADDR_W'(FW'(row_s) * FW'(MAP_WIDTH) + FW'(col_s));
   end

   always_comb begin
      last_d = gnt_any ? gnt_idx : last_q;
      s1_v_d = gnt_any;
      s1_oob_d = oob;
      s1_addr_d = addr;
      s1_ch_d = gnt_idx;
      pv_d[0] = s1_v_q;
      po_d[0] = s1_oob_q;
      pc_d[0] = s1_ch_q;
      for (int i = 1; i < L; i++) begin
         pv_d[i] = pv_q[i-1];
         po_d[i] = po_q[i-1];
         pc_d[i] = pc_q[i-1];
      end
      rsp_valid_d = '0;
      rsp_oob_d = rsp_oob_q;
      rsp_data_d = rsp_data_q;
      for (int c = 0; c < NUM_CH; c++) begin
         rsp_valid_d[c] = pv_q[L-1] && pc_q[L-1] == CW'(c);
         rsp_oob_d[c] = rsp_valid_d[c] ? po_q[L-1] : rsp_oob_q[c];
         rsp_data_d[c*DATA_W +: DATA_W] = rsp_valid_d[c] ? (po_q[L-1] ? OOB_VALUE : mem_dout)
                                                          : rsp_data_q[c*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= CW'(NUM_CH - 1);
         s1_v_q <= 1'b0;
         s1_oob_q <= 1'b0;
         s1_addr_q <= '0;
         s1_ch_q <= '0;
         pv_q <= '0;
         po_q <= '0;
         pc_q <= '{default: '0};
         rsp_valid_q <= '0;
         rsp_oob_q <= '0;
         rsp_data_q <= '0;
      end else begin
         last_q <= last_d;
         s1_v_q <= s1_v_d;
         s1_oob_q <= s1_oob_d;
         s1_addr_q <= s1_addr_d;
         s1_ch_q <= s1_ch_d;
         pv_q <= pv_d;
         po_q <= po_d;
         pc_q <= pc_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_oob_q <= rsp_oob_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign mem_en = s1_v_q && !s1_oob_q;
   assign mem_addr = mem_en ? s1_addr_q : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_oob = rsp_oob_q;
   assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_maze_map_port.sv
// tb_maze_map_port: directed checks of maze_map_port with latency-1 and latency-3 memory models
module tb_maze_map_port;
   logic clk = 1'b0;
   logic reset;
   logic [3:0] req_valid;
   logic [39:0] req_col, req_row;
   logic [3:0] req_ready, rsp_valid, rsp_oob;
   logic [31:0] rsp_data;
   logic mem_en;
   logic [16:0] mem_addr;
   logic [7:0] mem_dout;
   logic [3:0] req_ready3, rsp_valid3, rsp_oob3;
   logic [31:0] rsp_data3;
   logic mem_en3;
   logic [16:0] mem_addr3;
   logic [7:0] mem_dout3;
   logic [16:0] p1;
   logic [16:0] p3 [3];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   maze_map_port dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_col(req_col), .req_row(req_row), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_oob(rsp_oob), .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
   );

   maze_map_port #(.ROM_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
      .req_col(req_col), .req_row(req_row), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
      .rsp_oob(rsp_oob3), .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_dout(mem_dout3)
   );

   function automatic logic [7:0] rom(input logic [16:0] a);
      return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h3C;
   endfunction

   always @(posedge clk) begin
      p1 <= mem_addr;
      p3[0] <= mem_addr3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign mem_dout = rom(p1);
   assign mem_dout3 = rom(p3[2]);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_ch(input int c, input int col, input int row);
      req_col[c*10 +: 10] = 10'(col);
      req_row[c*10 +: 10] = 10'(row);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 4'b1111;
      req_col = '0;
      req_row = '0;
      cyc();
      check("ready_in_reset", 32'(req_ready), 0);
      cyc();
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_oob", 32'(rsp_oob), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      req_valid = '0;
      reset = 1'b0;
      cyc();
      // single in-bounds lookup on ch0
      set_ch(0, 10, 20);
      req_valid = 4'b0001;
      #1 check("ch0_ready", 32'(req_ready), 32'b0001);
      cyc();
      req_valid = '0;
      check("ch0_mem_en", 32'(mem_en), 1);
      check("ch0_mem_addr", 32'(mem_addr), 3205);
      check("ch0_rsp_early", 32'(rsp_valid), 0);
      cyc();
      check("ch0_rsp_not_yet", 32'(rsp_valid), 0);
      cyc();
      check("ch0_rsp_valid", 32'(rsp_valid), 32'b0001);
      check("ch0_rsp_data", 32'(rsp_data[7:0]), 32'(rom(17'd3205)));
      check("ch0_rsp_oob", 32'(rsp_oob[0]), 0);
      cyc();
      check("ch0_rsp_one_cycle", 32'(rsp_valid), 0);
      // ch1 corner in bounds, then column just past the edge
      set_ch(1, 639, 479);
      req_valid = 4'b0010;
      cyc();
      check("ch1_edge_mem_en", 32'(mem_en), 1);
      check("ch1_edge_addr", 32'(mem_addr), 76799);
      set_ch(1, 640, 0);
      cyc();
      req_valid = '0;
      check("ch1_oob_mem_en", 32'(mem_en), 0);
      check("ch1_oob_mem_addr", 32'(mem_addr), 0);
      cyc();
      check("ch1_edge_rsp_valid", 32'(rsp_valid), 32'b0010);
      check("ch1_edge_rsp_data", 32'(rsp_data[15:8]), 32'(rom(17'd76799)));
      check("ch1_edge_rsp_oob", 32'(rsp_oob[1]), 0);
      cyc();
      check("ch1_oob_rsp_valid", 32'(rsp_valid), 32'b0010);
      check("ch1_oob_rsp_oob", 32'(rsp_oob[1]), 1);
      check("ch1_oob_rsp_data", 32'(rsp_data[15:8]), 32'hFF);
      check("ch0_data_held", 32'(rsp_data[7:0]), 32'(rom(17'd3205)));
      // all channels requesting: strict rotation, responses in order
      do_reset();
      for (int c = 0; c < 4; c++) set_ch(c, 2 * c, 0);
      req_valid = 4'b1111;
      for (int j = 0; j < 10; j++) begin
         if (j == 8) req_valid = '0;
         #1;
         if (j < 8) check($sformatf("rr_grant_%0d", j), 32'(req_ready), 32'(1) << (j % 4));
         cyc();
         if (j >= 2) begin
            check($sformatf("rr_rsp_%0d", j), 32'(rsp_valid), 32'(1) << ((j - 2) % 4));
            check($sformatf("rr_data_%0d", j), 32'(rsp_data[((j - 2) % 4) * 8 +: 8]), 32'(rom(17'((j - 2) % 4))));
         end else check($sformatf("rr_rsp_%0d", j), 32'(rsp_valid), 0);
      end
      cyc();
      check("rr_drained", 32'(rsp_valid), 0);
      // two requesters alternate without idle cycles
      req_valid = 4'b1010;
      for (int j = 0; j < 4; j++) begin
         #1 check($sformatf("alt_grant_%0d", j), 32'(req_ready), (j % 2 == 1) ? 32'b1000 : 32'b0010);
         cyc();
      end
      req_valid = '0;
      cyc();
      cyc();
      cyc();
      // reset right after a ch2 acceptance drops it and re-arms priority at ch0
      set_ch(2, 4, 4);
      req_valid = 4'b0100;
      #1 check("rst_pre_grant", 32'(req_ready), 32'b0100);
      cyc();
      reset = 1'b1;
      req_valid = 4'b1010;
      #1 check("rst_ready_low", 32'(req_ready), 0);
      cyc();
      check("rst_flush_rsp", 32'(rsp_valid), 0);
      check("rst_flush_mem_en", 32'(mem_en), 0);
      reset = 1'b0;
      #1 check("rst_first_grant", 32'(req_ready), 32'b0010);
      cyc();
      req_valid = '0;
      check("rst_no_ch2_a", 32'(rsp_valid), 0);
      cyc();
      check("rst_no_ch2_b", 32'(rsp_valid), 0);
      cyc();
      check("rst_ch1_rsp", 32'(rsp_valid), 32'b0010);
      // latency-3 build: ch0 then ch3 back to back
      do_reset();
      set_ch(0, 10, 20);
      req_valid = 4'b0001;
      cyc();
      set_ch(3, 4, 2);
      req_valid = 4'b1000;
      cyc();
      req_valid = '0;
      for (int e = 2; e <= 6; e++) begin
         cyc();
         check($sformatf("lat3_rsp_%0d", e), 32'(rsp_valid3), e == 4 ? 32'b0001 : e == 5 ? 32'b1000 : 32'b0);
         if (e == 4) check("lat3_ch0_data", 32'(rsp_data3[7:0]), 32'(rom(17'd3205)));
         if (e == 5) check("lat3_ch3_data", 32'(rsp_data3[31:24]), 32'(rom(17'd322)));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
